// File: rtl/ppu_stream_gen.sv
// NES-style PPU dot timing and test-pattern stream generator.
// A 4-phase clock divider drives dot/scanline counters; pixel colour comes from a per-frame pattern or external memory.
module ppu_stream_gen #(
  parameter int CLK_DIV   = 4,
  parameter bit SKIP_ODD  = 1'b1,
  parameter int LINES     = 262,
  parameter int VIS_LINES = 240
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic [5:0] solid_color,
  output logic       clk_ppu,
  output logic       ppu_ce,
  output logic [5:0] color,
  output logic [8:0] scanline,
  output logic [8:0] cycle,
  output logic       frame_start,
  output logic       frame_odd,
  output logic       mem_rd,
  output logic [15:0] mem_addr,
  input  logic [5:0] mem_data
);

  localparam logic [1:0] DIV_LAST  = 2'(CLK_DIV - 1);
  localparam logic [8:0] LAST_DOT  = 9'd340;
  localparam logic [8:0] LAST_LINE = 9'(LINES - 1);
  localparam logic [8:0] VIS_Y     = 9'(VIS_LINES);

  logic [1:0] div_q, div_d;
  logic [8:0] cycle_q, cycle_d;
  logic [8:0] line_q, line_d;
  logic       odd_q, odd_d;
  logic [5:0] color_q, color_d;
  logic [1:0] mode_q, mode_d;
  logic [5:0] solid_q, solid_d;
  logic [5:0] mdata_q, mdata_d;

  logic       ce;
  logic       end_of_line;
  logic       wrap;
  logic [8:0] nxt_cycle;
  logic [8:0] nxt_line;
  logic       nxt_vis;
  logic [7:0] nx;
  logic [7:0] ny;

  function automatic logic [5:0] pixel_color(input logic [1:0] pmode,
                                             input logic [5:0] psolid,
                                             input logic [7:0] px,
                                             input logic [7:0] py,
                                             input logic [5:0] pmem);
    logic [5:0] c;
    case (pmode)
      2'd0:    c = psolid;
      2'd1:    c = {px[7:5], 3'b001};
      2'd2:    c = (px[3] ^ py[3]) ? 6'h30 : 6'h0F;
      default: c = pmem;
    endcase
    return c;
  endfunction

  // Next dot: the position the coming ppu_ce will enter; odd frames drop the last dot of the final line.
  always_comb begin
    end_of_line = (cycle_q == LAST_DOT) ||
                  (SKIP_ODD && odd_q && (line_q == LAST_LINE) && (cycle_q == LAST_DOT - 9'd1));
    wrap        = end_of_line && (line_q == LAST_LINE);
    nxt_cycle   = end_of_line ? 9'd0 : cycle_q + 9'd1;
    if (!end_of_line)
      nxt_line = line_q;
    else if (line_q == LAST_LINE)
      nxt_line = 9'd0;
    else
      nxt_line = line_q + 9'd1;
    nxt_vis = (nxt_line < VIS_Y) && (nxt_cycle != 9'd0) && (nxt_cycle <= 9'd256);
    nx      = nxt_cycle[7:0] - 8'd1;
    ny      = nxt_line[7:0];
  end

  assign ce          = rst_n && enable && (div_q == DIV_LAST);
  assign ppu_ce      = ce;
  assign frame_start = ce && wrap;
  assign clk_ppu     = div_q[1];
  assign mem_rd      = rst_n && enable && (div_q == 2'd1) && (mode_q == 2'd3) && nxt_vis;
  assign mem_addr    = {ny, nx};

  assign color       = color_q;
  assign scanline    = line_q;
  assign cycle       = cycle_q;
  assign frame_odd   = odd_q;

  always_comb begin
    div_d   = div_q;
    cycle_d = cycle_q;
    line_d  = line_q;
    odd_d   = odd_q;
    color_d = color_q;
    mode_d  = mode_q;
    solid_d = solid_q;
    mdata_d = mdata_q;
    if (enable)
      div_d = div_q + 2'd1;
    // Read data returns one clk after the div==1 strobe, so it is held from div==2 until the dot edge.
    if (enable && (div_q == 2'd2) && (mode_q == 2'd3))
      mdata_d = mem_data;
    if (ce) begin
      cycle_d = nxt_cycle;
      line_d  = nxt_line;
      color_d = nxt_vis ? pixel_color(mode_q, solid_q, nx, ny, mdata_q) : 6'h00;
      if (wrap) begin
        odd_d   = ~odd_q;
        mode_d  = mode;
        solid_d = solid_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= 2'd0;
      cycle_q <= 9'd0;
      line_q  <= 9'd0;
      odd_q   <= 1'b0;
      color_q <= 6'h00;
      mode_q  <= 2'd0;
      solid_q <= 6'h00;
    end else begin
      div_q   <= div_d;
      cycle_q <= cycle_d;
      line_q  <= line_d;
      odd_q   <= odd_d;
      color_q <= color_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
    end
  end

  always_ff @(posedge clk) begin
    mdata_q <= mdata_d;
  end

endmodule

// File: tb/tb_ppu_stream_gen.sv
// Directed bench for ppu_stream_gen using a shortened frame (10 lines, 9 visible) to keep runs short.
module tb_ppu_stream_gen;

  localparam int LINES = 10;
  localparam int VIS   = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  mode;
  logic [5:0]  solid_color;
  logic        clk_ppu;
  logic        ppu_ce;
  logic [5:0]  color;
  logic [8:0]  scanline;
  logic [8:0]  cycle;
  logic        frame_start;
  logic        frame_odd;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [5:0]  mem_data;

  int vectors    = 0;
  int miscompares = 0;

  logic [5:0]  mem_q = 6'h00;
  logic [15:0] last_rd_addr = 16'h0000;
  int          rd_cnt = 0;
  int          bad_rd = 0;
  int          seen_340_odd = 0;
  int          ce_cnt = 0;
  int          fs_dots[$];

  ppu_stream_gen #(.CLK_DIV(4), .SKIP_ODD(1'b1), .LINES(LINES), .VIS_LINES(VIS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_color(solid_color),
    .clk_ppu(clk_ppu), .ppu_ce(ppu_ce), .color(color), .scanline(scanline), .cycle(cycle),
    .frame_start(frame_start), .frame_odd(frame_odd), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // Frame memory model: returns addr[5:0] one clk after the strobe.
  assign mem_data = mem_q;
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_q        <= mem_addr[5:0];
      last_rd_addr <= mem_addr;
      rd_cnt       <= rd_cnt + 1;
      if (scanline >= VIS || !enable || !rst_n) bad_rd <= bad_rd + 1;
    end
    if (rst_n && frame_odd && scanline == LINES - 1 && cycle == 340)
      seen_340_odd <= seen_340_odd + 1;
    if (!rst_n) ce_cnt <= 0;
    else if (ppu_ce) begin
      ce_cnt <= ce_cnt + 1;
      if (frame_start) fs_dots.push_back(ce_cnt + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dot(input int sl, input int cy);
    int n = 0;
    while (!(scanline == 9'(sl) && cycle == 9'(cy)) && n < 30000) begin
      tick();
      n++;
    end
    if (!(scanline == 9'(sl) && cycle == 9'(cy))) begin
      vectors++; miscompares++;
      $display("FAIL wait_dot: timeout at (%0d,%0d), wanted (%0d,%0d)", scanline, cycle, sl, cy);
    end
  endtask

  task automatic wait_ce();
    int n = 0;
    while (!ppu_ce && n < 8) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; mode = 2'd0; solid_color = 6'h00;
    repeat (3) tick();
    vectors++;
    if ({scanline, cycle} !== 18'd0) begin miscompares++; $display("FAIL reset_pos: got (%0d,%0d) want (0,0)", scanline, cycle); end
    vectors++;
    if (color !== 6'h00 || frame_odd !== 1'b0) begin miscompares++; $display("FAIL reset_color_odd: got %h/%b want 00/0", color, frame_odd); end
    vectors++;
    if ({ppu_ce, frame_start, mem_rd, clk_ppu} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_strobes: got %b want 0000", {ppu_ce, frame_start, mem_rd, clk_ppu});
    end
  endtask

  task automatic test_first_dot();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (ppu_ce !== 1'b0 || cycle !== 9'd0) begin miscompares++; $display("FAIL first_clk1: ce=%b cycle=%0d want 0/0", ppu_ce, cycle); end
    tick();
    vectors++;
    if (clk_ppu !== 1'b1 || ppu_ce !== 1'b0) begin miscompares++; $display("FAIL first_clk2: clk_ppu=%b ce=%b want 1/0", clk_ppu, ppu_ce); end
    tick();
    vectors++;
    if (ppu_ce !== 1'b1 || cycle !== 9'd0) begin miscompares++; $display("FAIL first_clk3: ce=%b cycle=%0d want 1/0", ppu_ce, cycle); end
    tick();
    vectors++;
    if (ppu_ce !== 1'b0 || cycle !== 9'd1 || scanline !== 9'd0) begin
      miscompares++; $display("FAIL first_dot: ce=%b at (%0d,%0d) want 0 at (0,1)", ppu_ce, scanline, cycle);
    end
  endtask

  task automatic test_ce_period();
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ppu_ce) n++;
    end
    vectors++;
    if (n != 10 || cycle !== 9'd11) begin miscompares++; $display("FAIL ce_period: %0d pulses cycle=%0d want 10/11", n, cycle); end
  endtask

  task automatic test_mode0_latch();
    solid_color = 6'h16;
    wait_dot(3, 5);
    vectors++;
    if (color !== 6'h00) begin miscompares++; $display("FAIL solid_old_frame: got %h want 00", color); end
  endtask

  task automatic test_frame_wrap();
    wait_dot(LINES - 1, 340);
    wait_ce();
    vectors++;
    if (frame_start !== 1'b1 || frame_odd !== 1'b0) begin
      miscompares++; $display("FAIL even_wrap_pulse: fs=%b odd=%b want 1/0", frame_start, frame_odd);
    end
    tick();
    vectors++;
    if ({scanline, cycle} !== 18'd0 || frame_odd !== 1'b1 || frame_start !== 1'b0 || color !== 6'h00) begin
      miscompares++; $display("FAIL even_wrap_state: (%0d,%0d) odd=%b fs=%b color=%h want (0,0) 1 0 00",
                              scanline, cycle, frame_odd, frame_start, color);
    end
  endtask

  task automatic test_solid_frame();
    wait_dot(0, 1);
    vectors++;
    if (color !== 6'h16) begin miscompares++; $display("FAIL solid_new_frame: got %h want 16", color); end
    solid_color = 6'h2A;
    mode = 2'd2;
    wait_dot(4, 20);
    vectors++;
    if (color !== 6'h16) begin miscompares++; $display("FAIL solid_held: got %h want 16", color); end
    wait_dot(VIS, 1);
    vectors++;
    if (color !== 6'h00) begin miscompares++; $display("FAIL solid_blank_line: got %h want 00", color); end
    wait_dot(LINES - 1, 339);
    wait_ce();
    vectors++;
    if (frame_start !== 1'b1) begin miscompares++; $display("FAIL odd_short_pulse: fs=%b want 1", frame_start); end
    tick();
    vectors++;
    if ({scanline, cycle} !== 18'd0 || frame_odd !== 1'b0 || color !== 6'h00) begin
      miscompares++; $display("FAIL odd_wrap_state: (%0d,%0d) odd=%b color=%h want (0,0) 0 00", scanline, cycle, frame_odd, color);
    end
  endtask

  task automatic test_checker();
    wait_dot(0, 1);
    vectors++;
    if (color !== 6'h0F) begin miscompares++; $display("FAIL chk_x0_y0: got %h want 0F", color); end
    wait_dot(0, 9);
    vectors++;
    if (color !== 6'h30) begin miscompares++; $display("FAIL chk_x8_y0: got %h want 30", color); end
    wait_dot(8, 1);
    vectors++;
    if (color !== 6'h30) begin miscompares++; $display("FAIL chk_x0_y8: got %h want 30", color); end
    mode = 2'd1;
    wait_dot(8, 9);
    vectors++;
    if (color !== 6'h0F) begin miscompares++; $display("FAIL chk_x8_y8: got %h want 0F", color); end
  endtask

  task automatic test_bars();
    wait_dot(2, 1);
    vectors++;
    if (color !== 6'h01) begin miscompares++; $display("FAIL bar_x0: got %h want 01", color); end
    wait_dot(2, 33);
    vectors++;
    if (color !== 6'h09) begin miscompares++; $display("FAIL bar_x32: got %h want 09", color); end
    wait_dot(2, 256);
    vectors++;
    if (color !== 6'h39) begin miscompares++; $display("FAIL bar_x255: got %h want 39", color); end
    mode = 2'd3;
    wait_dot(2, 257);
    vectors++;
    if (color !== 6'h00) begin miscompares++; $display("FAIL bar_hblank: got %h want 00", color); end
  endtask

  task automatic test_memory();
    wait_dot(0, 0);
    vectors++;
    if (rd_cnt != 0) begin miscompares++; $display("FAIL no_rd_other_modes: got %0d reads want 0", rd_cnt); end
    wait_dot(1, 0);
    vectors++;
    if (rd_cnt != 256) begin miscompares++; $display("FAIL rd_per_line: got %0d want 256", rd_cnt); end
    wait_dot(5, 10);
    vectors++;
    if (color !== 6'h09 || last_rd_addr !== 16'h0509) begin
      miscompares++; $display("FAIL mem_5_10: color=%h addr=%h want 09/0509", color, last_rd_addr);
    end
    wait_dot(6, 70);
    vectors++;
    if (color !== 6'h05 || last_rd_addr !== 16'h0645) begin
      miscompares++; $display("FAIL mem_6_70: color=%h addr=%h want 05/0645", color, last_rd_addr);
    end
  endtask

  task automatic test_stall();
    logic       held;
    logic [5:0] c0;
    int         n;
    wait_dot(7, 50);
    c0 = color;
    held = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (scanline !== 9'd7 || cycle !== 9'd50 || ppu_ce !== 1'b0 || color !== c0) held = 1'b0;
    end
    vectors++;
    if (held !== 1'b1) begin miscompares++; $display("FAIL stall_hold: now (%0d,%0d) color=%h want (7,50) %h", scanline, cycle, color, c0); end
    enable = 1'b1;
    n = 0;
    while (cycle == 9'd50 && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (n != 4 || cycle !== 9'd51 || scanline !== 9'd7 || color !== 6'h32) begin
      miscompares++; $display("FAIL stall_resume: %0d clks to (%0d,%0d) color=%h want 4 (7,51) 32", n, scanline, cycle, color);
    end
  endtask

  task automatic test_frame_lengths();
    vectors++;
    if (fs_dots.size() < 4) begin
      miscompares++; $display("FAIL frame_count: got %0d frame_starts want >=4", fs_dots.size());
    end else begin
      vectors++;
      if (fs_dots[0] != 3410 || fs_dots[1] != 6819 || fs_dots[2] != 10229 || fs_dots[3] != 13638) begin
        miscompares++; $display("FAIL frame_lengths: got %0d %0d %0d %0d want 3410 6819 10229 13638",
                                fs_dots[0], fs_dots[1], fs_dots[2], fs_dots[3]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int rd0;
    wait_dot(7, 60);
    tick();
    vectors++;
    if (mem_rd !== 1'b1) begin miscompares++; $display("FAIL rd_before_reset: mem_rd=%b want 1", mem_rd); end
    rd0 = rd_cnt;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_rd !== 1'b0) begin miscompares++; $display("FAIL rd_in_reset: mem_rd=%b want 0", mem_rd); end
    tick();
    vectors++;
    if ({scanline, cycle} !== 18'd0 || color !== 6'h00 || clk_ppu !== 1'b0 || rd_cnt != rd0) begin
      miscompares++; $display("FAIL mid_reset: (%0d,%0d) color=%h clk_ppu=%b reads=%0d want (0,0) 00 0 %0d",
                              scanline, cycle, color, clk_ppu, rd_cnt, rd0);
    end
    tick();
    rst_n = 1'b1;
    wait_dot(0, 1);
    vectors++;
    if (color !== 6'h00 || rd_cnt != rd0) begin
      miscompares++; $display("FAIL latch_reset: color=%h reads=%0d want 00 %0d", color, rd_cnt, rd0);
    end
  endtask

  task automatic test_invariants();
    vectors++;
    if (bad_rd != 0) begin miscompares++; $display("FAIL rd_blank_or_disabled: got %0d want 0", bad_rd); end
    vectors++;
    if (seen_340_odd != 0) begin miscompares++; $display("FAIL odd_dot_340: got %0d want 0", seen_340_odd); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; mode = 2'd0; solid_color = 6'h00;
    test_reset();
    test_first_dot();
    test_ce_period();
    test_mode0_latch();
    test_frame_wrap();
    test_solid_frame();
    test_checker();
    test_bars();
    test_memory();
    test_stall();
    test_frame_lengths();
    test_mid_reset();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
